// File: rtl/if_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_if
// Bundles the instruction-memory request port and the decode-side
// instruction stream of the fetch front end.
//   imem_req/imem_addr     : fetch request and word address (fetch side drives)
//   imem_ack/imem_rdata    : request accepted, read data valid (memory drives)
//   inst_valid/inst_ready  : queue-head handshake toward decode
//   inst/inst_pc/inst_pc_4 : head instruction word, its PC and PC+4
//   inst_vec               : head violation vector, 0 = none
// Modports: master = fetch unit, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface if_fetch_queue_if #(
    parameter int XLEN     = 32,
    parameter int VEC_BITS = 5
);
    logic                imem_req;
    logic [XLEN-1:0]     imem_addr;
    logic                imem_ack;
    logic [XLEN-1:0]     imem_rdata;
    logic                inst_valid;
    logic                inst_ready;
    logic [XLEN-1:0]     inst;
    logic [XLEN-1:0]     inst_pc;
    logic [XLEN-1:0]     inst_pc_4;
    logic [VEC_BITS-1:0] inst_vec;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst, inst_pc, inst_pc_4, inst_vec,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst, inst_pc, inst_pc_4, inst_vec,
        output inst_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch front end: next-PC selection (sequential, jump, branch,
// register jump, rfe, exception vector), req/ack instruction-memory fetch and
// a QDEPTH-entry instruction queue feeding decode.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pc_write              : fetch enable (low = no new requests, PC holds)
//   pc_src                : 0 seq, 1 jump, 2 branch, 3 register jump
//   pc_hi_id, jmp_offset  : jump target = {pc_hi_id, jmp_offset}
//   beq_target, jr_target : branch / register-jump targets
//   rfe, iar_pc           : return from exception and its saved PC
//   exception, vector_no  : take exception to vector_no << VEC_SHIFT
//   s_u                   : 1 supervisor, 0 user (user fetch below USER_BASE
//                           is tagged with IV_CODE)
//   bus (master)          : imem req/ack port and decode-side inst stream
// Optional feature: define IF_MISALIGN_CHECK_EN to turn a misaligned PC into
// a single MISALIGN_CODE entry and halt fetch until the next redirect.
// Without it the fetch address is word aligned and PC[1:0] rides along.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int                  XLEN          = 32,
    parameter int                  QDEPTH        = 4,
    parameter logic [XLEN-1:0]     RESET_PC      = 32'h0000_0010,
    parameter int                  VEC_BITS      = 5,
    parameter int                  VEC_SHIFT     = 3,
    parameter logic [XLEN-1:0]     USER_BASE     = 32'h0000_1000,
    parameter logic [VEC_BITS-1:0] IV_CODE       = 5'd6,
    parameter logic [VEC_BITS-1:0] MISALIGN_CODE = 5'd7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_write,
    input  logic [1:0]          pc_src,
    input  logic [3:0]          pc_hi_id,
    input  logic [XLEN-5:0]     jmp_offset,
    input  logic [XLEN-1:0]     beq_target,
    input  logic [XLEN-1:0]     jr_target,
    input  logic                rfe,
    input  logic [XLEN-1:0]     iar_pc,
    input  logic                exception,
    input  logic [VEC_BITS-1:0] vector_no,
    input  logic                s_u,
    if_fetch_queue_if.master    bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(QDEPTH);
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

    logic [XLEN-1:0]     pc_reg;
    logic [CW-1:0]       count_reg;
    logic [PW-1:0]       head_reg;
    logic [PW-1:0]       tail_reg;

    logic [XLEN-1:0]     data_mem [QDEPTH];
    logic [XLEN-1:0]     pc_mem   [QDEPTH];
    logic [VEC_BITS-1:0] vec_mem  [QDEPTH];

    logic                redirect;
    logic [XLEN-1:0]     target;
    logic                full;
    logic                valid;
    logic                pop;
    logic                push;
    logic                fetch_done;
    logic                issue_ok;
    logic [XLEN-1:0]     push_data;
    logic [VEC_BITS-1:0] push_vec;
    logic [VEC_BITS-1:0] user_vec;

    assign redirect = exception | rfe | (pc_src != 2'd0);

    always_comb begin
        target = pc_reg;
        if (exception)
            target = {{(XLEN-VEC_BITS){1'b0}}, vector_no} << VEC_SHIFT;
        else if (rfe)
            target = iar_pc;
        else begin
            case (pc_src)
                2'd1:    target = {pc_hi_id, jmp_offset};
                2'd2:    target = beq_target;
                2'd3:    target = jr_target;
                default: target = pc_reg;
            endcase
        end
    end

    assign full     = (count_reg == DEPTH_C);
    assign valid    = (count_reg != '0);
    assign pop      = valid & bus.inst_ready;
    assign user_vec = (!s_u && (pc_reg < USER_BASE)) ? IV_CODE : '0;

`ifdef IF_MISALIGN_CHECK_EN
    logic halt_reg;
    logic misaligned;
    logic err_push;

    assign misaligned = (pc_reg[1:0] != 2'b00);
    // rst_n gate keeps the request low while reset is held.
    assign issue_ok   = rst_n & pc_write & ~redirect & ~full & ~halt_reg;
    assign bus.imem_req  = issue_ok & ~misaligned;
    assign bus.imem_addr = pc_reg;
    assign err_push   = issue_ok & misaligned;
    assign fetch_done = bus.imem_req & bus.imem_ack;
    assign push       = fetch_done | err_push;
    assign push_data  = err_push ? '0 : bus.imem_rdata;
    assign push_vec   = err_push ? MISALIGN_CODE : user_vec;

    // Once the misalign entry is queued, fetch stays parked until a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt_reg <= 1'b0;
        else if (redirect)
            halt_reg <= 1'b0;
        else if (err_push)
            halt_reg <= 1'b1;
    end
`else
    assign issue_ok      = rst_n & pc_write & ~redirect & ~full;
    assign bus.imem_req  = issue_ok;
    assign bus.imem_addr = {pc_reg[XLEN-1:2], 2'b00};
    assign fetch_done    = bus.imem_req & bus.imem_ack;
    assign push          = fetch_done;
    assign push_data     = bus.imem_rdata;
    assign push_vec      = user_vec;
`endif

    // PC, pointers and occupancy. A redirect empties the queue; a pop in the
    // same cycle has already been presented to decode, so nothing is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else if (redirect) begin
            pc_reg    <= target;
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            if (fetch_done)
                pc_reg <= pc_reg + FOUR;
            if (pop)
                head_reg <= head_reg + 1'b1;
            if (push)
                tail_reg <= tail_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue storage has no reset: contents are only visible behind count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail_reg] <= push_data;
            pc_mem[tail_reg]   <= pc_reg;
            vec_mem[tail_reg]  <= push_vec;
        end
    end

    assign bus.inst_valid = valid;
    assign bus.inst       = valid ? data_mem[head_reg] : '0;
    assign bus.inst_pc    = valid ? pc_mem[head_reg] : '0;
    assign bus.inst_pc_4  = valid ? (pc_mem[head_reg] + FOUR) : '0;
    assign bus.inst_vec   = valid ? vec_mem[head_reg] : '0;
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write, rfe, exception, s_u;
    logic [1:0]  pc_src;
    logic [3:0]  pc_hi_id;
    logic [27:0] jmp_offset;
    logic [31:0] beq_target, jr_target, iar_pc;
    logic [4:0]  vector_no;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(32), .VEC_BITS(5)) bus ();

    // Memory returns a word derived from its address so each entry is unique.
    assign bus.imem_rdata = bus.imem_addr ^ K;

    if_fetch_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .pc_hi_id   (pc_hi_id),
        .jmp_offset (jmp_offset),
        .beq_target (beq_target),
        .jr_target  (jr_target),
        .rfe        (rfe),
        .iar_pc     (iar_pc),
        .exception  (exception),
        .vector_no  (vector_no),
        .s_u        (s_u),
        .bus        (bus)
    );

    typedef struct {
        logic        pw;
        logic [1:0]  src;
        logic [31:0] br;
        logic        exc;
        logic [4:0]  vno;
        logic        rfe;
        logic [31:0] iar;
        logic        su;
        logic        ack;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_vec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic pw, logic [1:0] src, logic [31:0] br,
                                logic exc, logic [4:0] vno, logic rf, logic [31:0] iar,
                                logic su, logic ack, logic rdy,
                                logic e_req, logic [31:0] e_addr, logic e_valid,
                                logic [31:0] e_pc, logic [4:0] e_vec);
        vec_t v;
        v.pw = pw; v.src = src; v.br = br; v.exc = exc; v.vno = vno;
        v.rfe = rf; v.iar = iar; v.su = su; v.ack = ack; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_vec = e_vec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc, input logic [4:0] e_vec);
        logic [31:0] e_inst, e_pc4, e_pcx;
        logic [4:0]  e_vx;
        e_inst = e_valid ? (e_pc ^ K) : 32'h0;
        e_pcx  = e_valid ? e_pc : 32'h0;
        e_pc4  = e_valid ? (e_pc + 32'd4) : 32'h0;
        e_vx   = e_valid ? e_vec : 5'd0;
        chk({tag, " imem_req"},   {31'd0, bus.imem_req},   {31'd0, e_req});
        chk({tag, " imem_addr"},  bus.imem_addr,           e_addr);
        chk({tag, " inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, e_valid});
        chk({tag, " inst"},       bus.inst,                e_inst);
        chk({tag, " inst_pc"},    bus.inst_pc,             e_pcx);
        chk({tag, " inst_pc_4"},  bus.inst_pc_4,           e_pc4);
        chk({tag, " inst_vec"},   {27'd0, bus.inst_vec},   {27'd0, e_vx});
    endtask

    task automatic apply(input vec_t v);
        pc_write       = v.pw;
        pc_src         = v.src;
        pc_hi_id       = v.br[31:28];
        jmp_offset     = v.br[27:0];
        beq_target     = v.br;
        jr_target      = v.br;
        exception      = v.exc;
        vector_no      = v.vno;
        rfe            = v.rfe;
        iar_pc         = v.iar;
        s_u            = v.su;
        bus.imem_ack   = v.ack;
        bus.inst_ready = v.rdy;
    endtask

    initial begin
        vec_t idle;
        //               pw src br          exc vno rfe iar          su ack rdy | req addr         vld pc           vec
        // sequential fetch, one per cycle
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h10,   0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h14,   1, 32'h10,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h18,   1, 32'h14,   0));
        // decode stalled: fill to QDEPTH, then request drops
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 0,  1, 32'h1C,   1, 32'h18,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 0,  1, 32'h20,   1, 32'h18,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 0,  1, 32'h24,   1, 32'h18,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 0,  0, 32'h28,   1, 32'h18,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  0, 32'h28,   1, 32'h18,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h28,   1, 32'h1C,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h2C,   1, 32'h20,   0));
        // branch with 3 queued entries, ack during redirect ignored
        tv.push_back(mk(1, 2, 32'h200,    0, 0, 0, 32'h0,      1, 1, 1,  0, 32'h30,   1, 32'h24,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h200,  0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h204,  1, 32'h200,  0));
        // exception beats rfe and pc_src
        tv.push_back(mk(1, 3, 32'h300,    1, 5, 1, 32'h1234,   1, 1, 1,  0, 32'h208,  1, 32'h204,  0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h28,   0, 32'h0,    0));
        // rfe beats pc_src
        tv.push_back(mk(1, 3, 32'h500,    0, 0, 1, 32'h1234,   1, 1, 1,  0, 32'h2C,   1, 32'h28,   0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h1234, 0, 32'h0,    0));
        // user-mode fetch around USER_BASE
        tv.push_back(mk(1, 1, 32'hFFC,    0, 0, 0, 32'h0,      0, 1, 1,  0, 32'h1238, 1, 32'h1234, 0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      0, 1, 1,  1, 32'hFFC,  0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      0, 1, 1,  1, 32'h1000, 1, 32'hFFC,  6));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h1004, 1, 32'h1000, 0));
        // same addresses in supervisor mode
        tv.push_back(mk(1, 1, 32'hFFC,    0, 0, 0, 32'h0,      1, 1, 1,  0, 32'h1008, 1, 32'h1004, 0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'hFFC,  0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h1000, 1, 32'hFFC,  0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h1004, 1, 32'h1000, 0));
        // pc_write low, then a wait state
        tv.push_back(mk(0, 0, 32'h0,      0, 0, 0, 32'h0,      1, 0, 1,  0, 32'h1008, 1, 32'h1004, 0));
        tv.push_back(mk(0, 0, 32'h0,      0, 0, 0, 32'h0,      1, 0, 1,  0, 32'h1008, 0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 0, 1,  1, 32'h1008, 0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h1008, 0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 0, 1,  1, 32'h100C, 1, 32'h1008, 0));
        // register jump
        tv.push_back(mk(1, 3, 32'h400,    0, 0, 0, 32'h0,      1, 1, 1,  0, 32'h100C, 0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 1, 1,  1, 32'h400,  0, 32'h0,    0));
        tv.push_back(mk(1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 0, 1,  1, 32'h404,  1, 32'h400,  0));

        idle = mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        apply(idle);

        // reset state
        #12;
        chk_all("reset", 1'b0, 32'h10, 1'b0, 32'h0, 5'd0);
        $display("[TB] reset checked");
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            apply(tv[i]);
            @(negedge clk);
            chk_all($sformatf("v%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_valid,
                    tv[i].e_pc, tv[i].e_vec);
            $display("[TB] v%0d addr=%h req=%b valid=%b inst_pc=%h vec=%0d", i,
                     bus.imem_addr, bus.imem_req, bus.inst_valid, bus.inst_pc, bus.inst_vec);
        end

        // reset mid-fetch: three entries queued, request outstanding
        @(posedge clk);
        #1;
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        chk_all("prerst", 1'b1, 32'h410, 1'b1, 32'h404, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("inrst", 1'b0, 32'h10, 1'b0, 32'h0, 5'd0);
        $display("[TB] reset mid-fetch valid=%b addr=%h", bus.inst_valid, bus.imem_addr);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("postrst", 1'b1, 32'h10, 1'b0, 32'h0, 5'd0);
        bus.imem_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        chk_all("firstpush", 1'b1, 32'h14, 1'b1, 32'h10, 5'd0);
        $display("[TB] post-reset fetch inst_pc=%h inst=%h", bus.inst_pc, bus.inst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
